// File: rtl/rgb2gray_stream.sv
`timescale 1ns/1ps
// rgb2gray_stream: serial RGB-to-gray converter.
// Three colour components per pixel arrive one per handshake. They are
// weighted and summed into an accumulator, and the sum is scaled by 1/256
// into a held result with a valid/ready output handshake. A frame of
// pix_count_i pixels starts with a one-cycle start_i pulse, and done_o
// pulses when the frame ends.
// Optional feature macro: RGB2GRAY_ROUND_EN (round-half-up instead of truncate).
module rgb2gray_stream #(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16,
  parameter int COEF_R   = 77,
  parameter int COEF_G   = 150,
  parameter int COEF_B   = 29,
  parameter int CH_ORDER = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  pix_count_i,
  input  logic [DATA_W-1:0] RgbColor_i,
  input  logic              comp_valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] GrayColor_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int ACC_W = DATA_W + 9;

  // Weight for each serial position; the first and last positions swap
  // between red and blue depending on the input component order.
  localparam logic [7:0] W0 = (CH_ORDER == 0) ? 8'(COEF_R) : 8'(COEF_B);
  localparam logic [7:0] W1 = 8'(COEF_G);
  localparam logic [7:0] W2 = (CH_ORDER == 0) ? 8'(COEF_B) : 8'(COEF_R);

  // The weights must form a unity gain of 256 so the >>8 scaling is exact.
  if (COEF_R + COEF_G + COEF_B != 256) begin : g_coef_sum_check
    $error("rgb2gray_stream: COEF_R + COEF_G + COEF_B must equal 256");
  end
  if (CH_ORDER != 0 && CH_ORDER != 1) begin : g_order_check
    $error("rgb2gray_stream: CH_ORDER must be 0 or 1");
  end

  typedef enum logic [1:0] {IDLE, C0, C1, C2} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc_p0;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_dec;
  logic [7:0]         comp_w;
  logic [ACC_W-1:0]   comp_prod;
  logic [ACC_W-1:0]   acc_sum;
  logic               accept;

  // Weighted value of one component, widened to the accumulator width.
  function automatic logic [ACC_W-1:0] weigh(input logic [DATA_W-1:0] c,
                                             input logic [7:0]        w);
    return ACC_W'(c) * ACC_W'(w);
  endfunction

  // Scale the weighted sum by 1/256 (optionally rounding) and clamp to full scale.
  function automatic logic [DATA_W-1:0] round_sat(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0]  adj;
    logic [DATA_W:0]   q;
`ifdef RGB2GRAY_ROUND_EN
    adj = sum + ACC_W'(128);
`else
    adj = sum;
`endif
    q = adj[ACC_W-1:8];
    if (q > {1'b0, {DATA_W{1'b1}}}) begin
      return {DATA_W{1'b1}};
    end
    return q[DATA_W-1:0];
  endfunction

  // Handshake decode and per-position weighting of the incoming component.
  always_comb begin
    busy_o  = (state != IDLE);
    ready_o = busy_o && (!valid_o || ready_i);
    accept  = comp_valid_i && ready_o;
    comp_w  = W2;
    if (state == C0) begin
      comp_w = W0;
    end else if (state == C1) begin
      comp_w = W1;
    end
    comp_prod = weigh(RgbColor_i, comp_w);
    acc_sum   = acc_p0 + comp_prod;
    cnt_dec   = cnt - CNT_W'(1);
  end

  // Frame FSM: component accumulation, result register and frame counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      acc_p0      <= '0;
      cnt         <= '0;
      GrayColor_o <= '0;
      valid_o     <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            cnt <= pix_count_i;
            if (pix_count_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state <= C0;
            end
          end
        end
        C0: begin
          if (accept) begin
            acc_p0 <= comp_prod;
            state  <= C1;
          end
        end
        C1: begin
          if (accept) begin
            acc_p0 <= acc_sum;
            state  <= C2;
          end
        end
        C2: begin
          if (accept) begin
            acc_p0      <= acc_sum;
            GrayColor_o <= round_sat(acc_sum);
            valid_o     <= 1'b1;
            cnt         <= cnt_dec;
            if (cnt_dec == '0) begin
              state  <= IDLE;
              done_o <= 1'b1;
            end else begin
              state <= C0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2gray_stream.sv
`timescale 1ns/1ps
// Scoreboard bench for rgb2gray_stream: two instances (RGB and BGR order)
// share the stimulus; expected gray values are queued per instance and
// popped by a monitor on every output handshake.
module tb_rgb2gray_stream;

  localparam int LIMIT = 3000;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [15:0] pix_count_i;
  logic [7:0] comp;
  logic       comp_valid;
  logic       ready_i;

  logic       ready0, valid0, busy0, done0;
  logic [7:0] gray0;
  logic       ready1, valid1, busy1, done1;
  logic [7:0] gray1;

  int tests = 0;
  int fails = 0;
  int exp0[$];
  int exp1[$];
  int done_exp  = 0;
  int done_seen = 0;
  int gap_max   = 0;
  bit rdy_rand  = 0;
  bit rdy_force = 1;

  bit       pv = 0;
  bit       pr = 0;
  int       pg = 0;

  always #5 clk = ~clk;

  rgb2gray_stream #(.DATA_W(8), .CNT_W(16), .CH_ORDER(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pix_count_i(pix_count_i),
    .RgbColor_i(comp), .comp_valid_i(comp_valid), .ready_o(ready0),
    .GrayColor_o(gray0), .valid_o(valid0), .ready_i(ready_i),
    .busy_o(busy0), .done_o(done0));

  rgb2gray_stream #(.DATA_W(8), .CNT_W(16), .CH_ORDER(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pix_count_i(pix_count_i),
    .RgbColor_i(comp), .comp_valid_i(comp_valid), .ready_o(ready1),
    .GrayColor_o(gray1), .valid_o(valid1), .ready_i(ready_i),
    .busy_o(busy1), .done_o(done1));

  // Reference: luma from true r,g,b values with the default weights.
  function automatic int ref_gray(int r, int g, int b);
    int s;
    s = r * 77 + g * 150 + b * 29;
`ifdef RGB2GRAY_ROUND_EN
    s = s + 128;
`endif
    s = s / 256;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Downstream ready: either random backpressure or a forced level.
  always @(posedge clk) begin
    #1;
    ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor: pop and compare on every handshake, check hold under stall.
  always @(negedge clk) begin
    if (rst_i) begin
      if (valid0 && ready_i) begin
        if (exp0.size() == 0) check("unexpected_valid0", 1, 0);
        else check("gray_rgb", gray0, exp0.pop_front());
      end
      if (valid1 && ready_i) begin
        if (exp1.size() == 0) check("unexpected_valid1", 1, 0);
        else check("gray_bgr", gray1, exp1.pop_front());
      end
      if (pv && !pr) begin
        check("hold_valid", valid0, 1);
        check("hold_gray", gray0, pg);
      end
      if (done0) done_seen++;
      pv = valid0;
      pr = ready_i;
      pg = gray0;
    end else begin
      pv = 0;
      pr = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int n);
    start_i     = 1'b1;
    pix_count_i = 16'(n);
    tick();
    start_i     = 1'b0;
  endtask

  task automatic send_comp(input int c);
    bit a;
    int n;
    a = 0;
    n = 0;
    comp       = 8'(c);
    comp_valid = 1'b1;
    while (!a && n < LIMIT) begin
      @(negedge clk);
      a = ready0;
      tick();
      n++;
    end
    comp_valid = 1'b0;
    if (!a) check("comp_accept_timeout", 0, 1);
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
  endtask

  task automatic send_pixel(input int c0, input int c1, input int c2);
    exp0.push_back(ref_gray(c0, c1, c2));
    exp1.push_back(ref_gray(c2, c1, c0));
    send_comp(c0);
    send_comp(c1);
    send_comp(c2);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || valid0 || exp0.size() != 0) && n < LIMIT) begin
      tick();
      n++;
    end
    check("idle_reached", int'(n < LIMIT), 1);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; pix_count_i = '0;
    comp = '0; comp_valid = 1'b0; ready_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", valid0, 0);
    check("rst_busy", busy0, 0);
    check("rst_ready", ready0, 0);
    check("rst_done", done0, 0);
    check("rst_gray", gray0, 0);
    tick();
    rst_i = 1'b1;
    tick();

    // Full-scale white pixel, single-pixel frame.
    start_frame(1);
    done_exp++;
    check("busy_in_frame", busy0, 1);
    send_pixel(255, 255, 255);
    @(negedge clk);
    check("white_valid", valid0, 1);
    check("white_gray", gray0, 255);
    check("white_busy_drop", busy0, 0);
    check("white_done", done0, 1);
    tick();
    @(negedge clk);
    check("white_valid_one_cycle", valid0, 0);
    check("white_done_one_cycle", done0, 0);
    tick();

    // Rounding boundary and channel-order pixels.
    start_frame(1); done_exp++; send_pixel(0, 1, 0); wait_idle();
    start_frame(1); done_exp++; send_pixel(200, 50, 100); wait_idle();

    // Backpressure: first result taken, then ready_i held low.
    start_frame(3);
    done_exp++;
    send_pixel(10, 200, 30);
    begin
      int n = 0;
      while (exp0.size() != 0 && n < 100) begin tick(); n++; end
    end
    rdy_force = 0;
    tick();
    send_pixel(90, 40, 250);
    repeat (4) tick();
    @(negedge clk);
    check("bp_valid", valid0, 1);
    check("bp_ready_low", ready0, 0);
    check("bp_busy", busy0, 1);
    tick();
    rdy_force = 1;
    send_pixel(7, 180, 66);
    wait_idle();

    // start_i during a frame must not restart it.
    start_frame(2);
    done_exp++;
    start_i = 1'b1; pix_count_i = 16'd7;
    tick();
    start_i = 1'b0;
    send_pixel(1, 2, 3);
    send_pixel(123, 45, 67);
    wait_idle();
    repeat (3) tick();
    @(negedge clk);
    check("ignored_start_idle", busy0, 0);
    tick();

    // Zero-length frame.
    start_frame(0);
    done_exp++;
    @(negedge clk);
    check("zero_done", done0, 1);
    check("zero_busy", busy0, 0);
    check("zero_valid", valid0, 0);
    repeat (4) tick();
    @(negedge clk);
    check("zero_no_result", valid0, 0);
    tick();

    // Reset in the middle of the second pixel of a 3-pixel frame.
    start_frame(3);
    send_pixel(255, 255, 255);
    send_comp(10);
    send_comp(20);
    rst_i = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_gray", gray0, 0);
    check("midrst_valid", valid0, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_ready", ready0, 0);
    check("midrst_done", done0, 0);
    tick();
    rst_i = 1'b1;
    tick();

    // Randomized frames with random gaps and backpressure.
    rdy_rand = 1;
    gap_max  = 2;
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(1, 5);
      start_frame(n);
      done_exp++;
      for (int p = 0; p < n; p++) begin
        send_pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      end
      wait_idle();
    end
    rdy_rand = 0;
    gap_max  = 0;
    repeat (4) tick();

    check("done_count", done_seen, done_exp);
    check("queue_rgb_empty", exp0.size(), 0);
    check("queue_bgr_empty", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
